// File: rtl/mem_write_if.sv
// Write-side bus between the pattern generator and an AXI write master:
// burst request (wr_start/wr_addr/wr_size/wr_idle), data stream
// (data_out/data_out_valid/data_out_ready) and burst completion (wr_done).
//   master : the pattern generator (drives request and data)
//   slave  : the AXI write master (drives wr_idle, data_out_ready, wr_done)
interface mem_write_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned XFER_W = 32,
  parameter int unsigned DATA_W = 256
);
  logic              wr_start;
  logic [ADDR_W-1:0] wr_addr;
  logic [XFER_W-1:0] wr_size;
  logic              wr_idle;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_ready;
  logic              wr_done;

  modport master (
    output wr_start, wr_addr, wr_size, data_out, data_out_valid,
    input  wr_idle, data_out_ready, wr_done
  );

  modport slave (
    input  wr_start, wr_addr, wr_size, data_out, data_out_valid,
    output wr_idle, data_out_ready, wr_done
  );
endinterface

// File: rtl/mem_write.sv
// Memory write test-pattern generator. On start it issues fixed-size write
// bursts at base_address + n*addr_increment while the next offset stays within
// mem_max_addr, streaming an incrementing byte pattern seeded by pattern_seed.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a run (only honoured in IDLE)
//   base_address          first burst byte address
//   addr_increment        offset step between bursts
//   mem_max_addr          inclusive upper offset limit
//   pattern_seed          value of byte 0 of the run
//   done                  one-cycle pulse at the end of a run
//   burst_count           bursts completed in the current run
//   wr                    write-master bus (request, data stream, completion)
module mem_write #(
  parameter int unsigned C_AXIS_TDATA_WIDTH  = 256,
  parameter int unsigned C_M_AXI_ADDR_WIDTH  = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH   = 32,
  parameter int unsigned WRITE_DATA_SIZE     = 32,
  parameter int unsigned WRITE_MEM_ADDR_SIZE = 32,
  parameter int unsigned BEAT_CTR_SIZE       = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  base_address,
  input  logic [WRITE_MEM_ADDR_SIZE-1:0] addr_increment,
  input  logic [WRITE_MEM_ADDR_SIZE-1:0] mem_max_addr,
  input  logic [7:0]                     pattern_seed,
  output logic                           done,
  output logic [BEAT_CTR_SIZE-1:0]       burst_count,
  mem_write_if.master                    wr
);

  localparam int unsigned BYTES_PER_BEAT = C_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned BEATS_RAW      = (WRITE_DATA_SIZE * 8) / C_AXIS_TDATA_WIDTH;
  localparam int unsigned BEATS          = (BEATS_RAW == 0) ? 1 : BEATS_RAW;
  localparam int unsigned OFF_W          = WRITE_MEM_ADDR_SIZE;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    REQ       = 3'd2,
    STREAM    = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [OFF_W-1:0]                offset_q, offset_d;
  logic [BEAT_CTR_SIZE-1:0]        byte_cnt_q, byte_cnt_d;
  logic [BEAT_CTR_SIZE-1:0]        beat_cnt_q, beat_cnt_d;
  logic [BEAT_CTR_SIZE-1:0]        burst_cnt_q, burst_cnt_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   base_q, base_d;
  logic [OFF_W-1:0]                inc_q, inc_d;
  logic [OFF_W-1:0]                max_q, max_d;
  logic [7:0]                      seed_q, seed_d;
  logic                            done_q, done_d;
  logic                            wr_start_q, wr_start_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [C_XFER_SIZE_WIDTH-1:0]    wr_size_q, wr_size_d;
  logic [C_AXIS_TDATA_WIDTH-1:0]   data_q, data_d;
  logic                            valid_q, valid_d;

  // One extra bit so offset + increment can never wrap past the limit test
  logic [OFF_W:0]                  next_off_ext;
  logic [BEAT_CTR_SIZE-1:0]        byte_nxt;

  // Byte lane i carries seed + byte_counter + i (mod 256)
  function automatic logic [C_AXIS_TDATA_WIDTH-1:0] gen_beat(
    input logic [7:0]               seed,
    input logic [BEAT_CTR_SIZE-1:0] cnt
  );
    logic [C_AXIS_TDATA_WIDTH-1:0] beat;
    beat = '0;
    for (int unsigned i = 0; i < BYTES_PER_BEAT; i++) begin
      beat[8*i +: 8] = seed + 8'(cnt) + 8'(i);
    end
    return beat;
  endfunction

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    byte_cnt_d   = byte_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    base_d       = base_q;
    inc_d        = inc_q;
    max_d        = max_q;
    seed_d       = seed_q;
    done_d       = 1'b0;
    wr_start_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_size_d    = wr_size_q;
    data_d       = data_q;
    valid_d      = valid_q;
    next_off_ext = {1'b0, offset_q} + {1'b0, inc_q};
    byte_nxt     = byte_cnt_q + BEAT_CTR_SIZE'(BYTES_PER_BEAT);

    case (state_q)
      IDLE: begin
        if (start) begin
          offset_d    = '0;
          byte_cnt_d  = '0;
          burst_cnt_d = '0;
          base_d      = base_address;
          inc_d       = addr_increment;
          max_d       = mem_max_addr;
          seed_d      = pattern_seed;
          state_d     = CHECK;
        end
      end

      CHECK: begin
        if ((max_q == '0) || (inc_q == '0) || (next_off_ext > {1'b0, max_q})) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end

      // Request and first beat are registered together on the same edge
      REQ: begin
        if (wr.wr_idle) begin
          wr_start_d = 1'b1;
          wr_addr_d  = base_q + C_M_AXI_ADDR_WIDTH'(offset_q);
          wr_size_d  = C_XFER_SIZE_WIDTH'(WRITE_DATA_SIZE);
          offset_d   = offset_q + inc_q;
          beat_cnt_d = '0;
          data_d     = gen_beat(seed_q, byte_cnt_q);
          valid_d    = 1'b1;
          state_d    = STREAM;
        end
      end

      STREAM: begin
        if (valid_q && wr.data_out_ready) begin
          byte_cnt_d = byte_nxt;
          if (beat_cnt_q == BEAT_CTR_SIZE'(BEATS - 1)) begin
            valid_d = 1'b0;
            state_d = WAIT_DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_CTR_SIZE'(1);
            data_d     = gen_beat(seed_q, byte_nxt);
          end
        end
      end

      WAIT_DONE: begin
        if (wr.wr_done) begin
          burst_cnt_d = burst_cnt_q + BEAT_CTR_SIZE'(1);
          state_d     = CHECK;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      offset_q    <= '0;
      byte_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
      base_q      <= '0;
      inc_q       <= '0;
      max_q       <= '0;
      seed_q      <= '0;
      done_q      <= 1'b0;
      wr_start_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_size_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      byte_cnt_q  <= byte_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      base_q      <= base_d;
      inc_q       <= inc_d;
      max_q       <= max_d;
      seed_q      <= seed_d;
      done_q      <= done_d;
      wr_start_q  <= wr_start_d;
      wr_addr_q   <= wr_addr_d;
      wr_size_q   <= wr_size_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign done              = done_q;
  assign burst_count       = burst_cnt_q;
  assign wr.wr_start       = wr_start_q;
  assign wr.wr_addr        = wr_addr_q;
  assign wr.wr_size        = wr_size_q;
  assign wr.data_out       = data_q;
  assign wr.data_out_valid = valid_q;

endmodule
